// File: rtl/prv32_muldiv_unit.sv
// prv32_muldiv_unit
// Iterative RV32M multiply/divide unit used beside prv32_ALU in the execute
// stage. It runs all eight M-extension operations over several cycles under a
// start/busy/done handshake. Divide-by-zero and signed divide overflow finish
// on a one-cycle fast path, and a pipeline flush aborts the operation in flight.
//
// Ports:
//   clk     : clock, rising edge
//   rst     : asynchronous reset, active low
//   start   : request, sampled only while busy = 0
//   kill    : synchronous abort, overrides start
//   op      : RV32M funct3 (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU)
//   a, b    : rs1 / rs2 operands, sampled with start
//   busy    : operation in progress
//   done    : one-cycle pulse, result is valid in that cycle
//   result  : registered result, held until the next done
//
// Configuration macro:
//   PRV32_SINGLE_CYCLE_MUL_EN : when defined, multiplies form the full product
//   combinationally on the start edge and go straight to FIN (latency 1).

module prv32_muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            kill,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN + 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;

  state_t state_q, state_d;

  logic [2:0]        op_q;
  logic [2*XLEN-1:0] acc;
  logic [2*XLEN-1:0] mcand;
  logic [XLEN-1:0]   mplier;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   rem;
  logic [XLEN-1:0]   divisor;
  logic [CW-1:0]     cnt;
  logic              neg_p;
  logic              neg_q;
  logic              neg_r;

  logic              a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0]   abs_a, abs_b;
  logic              b_zero, div_ovf, div_fast;
  logic [XLEN:0]     shifted, diff;
  logic [2*XLEN-1:0] prod_f;
  logic [XLEN-1:0]   quo_f, rem_f, res_sel;

  // Signed views: a is signed for MULH/MULHSU/DIV/REM, b for MULH/DIV/REM.
  // The loops always work on magnitudes; signs are restored in FIN.
  assign a_signed = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
  assign b_signed = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
  assign a_neg    = a_signed & a[XLEN-1];
  assign b_neg    = b_signed & b[XLEN-1];
  assign abs_a    = a_neg ? -a : a;
  assign abs_b    = b_neg ? -b : b;

  // Divide cases whose answer is fixed by the ISA rather than computed.
  assign b_zero   = (b == '0);
  assign div_ovf  = ~op[0] & (a == {1'b1, {(XLEN-1){1'b0}}}) & (b == '1);
  assign div_fast = op[2] & (b_zero | div_ovf);

  // Restoring divide step. The partial remainder is always below the divisor,
  // so the shifted value fits in XLEN+1 bits and the MSB of the difference is
  // a clean borrow flag.
  assign shifted = {rem, quo[XLEN-1]};
  assign diff    = shifted - {1'b0, divisor};

  // Sign fix-up and output selection, consumed on the FIN edge.
  assign prod_f = neg_p ? -acc : acc;
  assign quo_f  = neg_q ? -quo : quo;
  assign rem_f  = neg_r ? -rem : rem;

  always_comb begin
    res_sel = quo_f;
    case (op_q)
      3'b000:                 res_sel = prod_f[XLEN-1:0];
      3'b001, 3'b010, 3'b011: res_sel = prod_f[2*XLEN-1:XLEN];
      3'b100, 3'b101:         res_sel = quo_f;
      default:                res_sel = rem_f;
    endcase
  end

`ifdef PRV32_SINGLE_CYCLE_MUL_EN
  logic [2*XLEN-1:0] full_prod;
  assign full_prod = {{XLEN{1'b0}}, abs_a} * {{XLEN{1'b0}}, abs_b};
`endif

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic. kill forces IDLE from any state, even over start.
  always_comb begin
    state_d = state_q;
    busy    = (state_q != IDLE);
    if (kill) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            if (op[2]) begin
              state_d = div_fast ? FIN : DIV;
            end else begin
`ifdef PRV32_SINGLE_CYCLE_MUL_EN
              state_d = FIN;
`else
              state_d = MUL;
`endif
            end
          end
        end
        MUL:     if (cnt == CW'(1)) state_d = FIN;
        DIV:     if (cnt == CW'(1)) state_d = FIN;
        default: state_d = IDLE;
      endcase
    end
  end

  // Datapath. Operands and sign flags are captured on acceptance; the fast
  // divide cases preload quotient/remainder with their fixed answers and clear
  // the sign flags so FIN passes them through untouched.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q    <= '0;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      quo     <= '0;
      rem     <= '0;
      divisor <= '0;
      cnt     <= '0;
      neg_p   <= 1'b0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      result  <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (!kill) begin
        case (state_q)
          IDLE: begin
            if (start) begin
              op_q    <= op;
              neg_p   <= a_neg ^ b_neg;
              neg_q   <= a_neg ^ b_neg;
              neg_r   <= a_neg;
              cnt     <= CW'(XLEN);
              acc     <= '0;
              mcand   <= {{XLEN{1'b0}}, abs_a};
              mplier  <= abs_b;
              quo     <= abs_a;
              rem     <= '0;
              divisor <= abs_b;
              if (op[2] && b_zero) begin
                quo   <= '1;
                rem   <= a;
                neg_q <= 1'b0;
                neg_r <= 1'b0;
              end else if (op[2] && div_ovf) begin
                quo   <= a;
                rem   <= '0;
                neg_q <= 1'b0;
                neg_r <= 1'b0;
              end
`ifdef PRV32_SINGLE_CYCLE_MUL_EN
              if (!op[2]) acc <= full_prod;
`endif
            end
          end
          MUL: begin
            if (mplier[0]) acc <= acc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt - 1'b1;
          end
          DIV: begin
            if (!diff[XLEN]) begin
              rem <= diff[XLEN-1:0];
              quo <= {quo[XLEN-2:0], 1'b1};
            end else begin
              rem <= shifted[XLEN-1:0];
              quo <= {quo[XLEN-2:0], 1'b0};
            end
            cnt <= cnt - 1'b1;
          end
          default: begin
            result <= res_sel;
            done   <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule
